// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared FSM encoding and default widths for ram_stream_ctrl
package ram_ctrl_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int LEN_W_DEF = 21;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;
endpackage

// File: rtl/ram_stream_ctrl_skid.sv
// ram_rd_skid: 2-entry FIFO holding RAM read data for the out_* stream
// Ports: clk, rst_n (sync, active-low); push/din write side; pop/head read side; count = occupancy 0..2.
module ram_rd_skid #(
  parameter int N_BITS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [N_BITS-1:0] din,
  output logic [1:0]        count,
  output logic [N_BITS-1:0] head
);
  logic [N_BITS-1:0] mem_q [2];
  logic [N_BITS-1:0] mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push ? din : mem_q[wr_q];
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/ram_stream_ctrl.sv
// ram_stream_ctrl: valid/ready stream <-> single-port ram_block initiator (WRITE, or READ via skid buffer)
// Optional feature macro RAM_CTRL_BOUNDS_CHECK_EN: base_addr+length > SIZE_N raises sticky err and skips the transfer.
// Ports: clk, rst_n (sync, active-low); start_wr/start_rd/base_addr/length start a transfer;
//   in_data/in_valid/in_ready write stream; out_data/out_valid/out_ready read stream;
//   busy/done/err status; ram_rw/ram_addr/ram_wdata/ram_rdata connect to ram_block.
module ram_stream_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int SIZE_N = 8,
  parameter int N_BITS = 64,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [N_BITS-1:0] ram_wdata,
  input  logic [N_BITS-1:0] ram_rdata
);
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, idx_n;
  logic [N_BITS-1:0] ram_wdata_q, ram_wdata_d;
  logic ram_rw_q, ram_rw_d, done_q, done_d, err_q, err_d;
  logic iss_q, iss_d, pend_q, pend_d;
  logic [1:0] count, cnt_next;
  logic push, pop, go, bad;
  // A word left on ram_rdata (pend_q) stays valid while ram_addr is held, so the RAM output
  // register acts as a third slot; a read is issued only if the skid will have room next cycle.
  always_comb begin
    pop = out_valid & out_ready;
    push = pend_q & ((count != 2'd2) | pop);
    cnt_next = count - {1'b0, pop} + {1'b0, push};
    go = (state_q == IDLE) & (start_wr | start_rd);
    bad = BOUNDS_EN & go & ((64'(base_addr) + 64'(length)) > 64'(SIZE_N));
    idx_n = idx_q + LEN_W'(1);
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    idx_d = idx_q;
    err_d = err_q;
    ram_rw_d = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    iss_d = 1'b0;
    done_d = state_q == DONE;
    case (state_q)
      IDLE: if (go) begin
        base_d = base_addr;
        len_d = length;
        err_d = bad;
        iss_d = !start_wr && !bad && length != '0;
        idx_d = LEN_W'(iss_d);
        ram_addr_d = iss_d ? base_addr : ram_addr_q;
        state_d = (bad || length == '0) ? DONE : start_wr ? WRITE : (length == LEN_W'(1)) ? DRAIN : READ;
      end
      WRITE: if (in_valid) begin
        ram_rw_d = 1'b1;
        ram_addr_d = base_q + ADDR_W'(idx_q);
        ram_wdata_d = in_data;
        idx_d = idx_n;
        state_d = (idx_n == len_q) ? DONE : WRITE;
      end
      READ: if (cnt_next < 2'd2) begin
        iss_d = 1'b1;
        ram_addr_d = base_q + ADDR_W'(idx_q);
        idx_d = idx_n;
        state_d = (idx_n == len_q) ? DRAIN : READ;
      end
      DRAIN: state_d = (!iss_q && !pend_q && count == 2'd0) ? DONE : DRAIN;
      DONE: begin
        idx_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_d = iss_q | (pend_q & ~push);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      ram_rw_q <= 1'b0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      iss_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      idx_q <= idx_d;
      err_q <= err_d;
      ram_rw_q <= ram_rw_d;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      iss_q <= iss_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end
  ram_rd_skid #(.N_BITS(N_BITS)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(ram_rdata),
    .count(count),
    .head(out_data)
  );
  assign in_ready = state_q == WRITE;
  assign out_valid = count != 2'd0;
  assign busy = (state_q != IDLE) | done_q;
  assign done = done_q;
  assign err = err_q;
  assign ram_rw = ram_rw_q;
  assign ram_addr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_stream_ctrl.sv
// tb_ram_stream_ctrl: randomized self-checking bench for ram_stream_ctrl with an 8x64 RAM model
`timescale 1ns/1ps
module tb_ram_stream_ctrl;
  localparam int N_BITS = 64;
  localparam int ADDR_W = 20;
  localparam int LEN_W = 21;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_wr = 1'b0;
  logic start_rd = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic [N_BITS-1:0] in_data = '0;
  logic in_ready, out_valid, busy, done, err, ram_rw;
  logic [N_BITS-1:0] out_data, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [N_BITS-1:0] ram_rdata = '0;
  logic [N_BITS-1:0] ram [8];
  logic [N_BITS-1:0] ref_mem [8];
  logic [N_BITS-1:0] wdat [16];
  logic [N_BITS-1:0] rd_q [$];
  logic [N_BITS-1:0] wd_q [$];
  logic [ADDR_W-1:0] wa_q [$];
  int rc_q [$];
  int wc_q [$];
  int checks = 0, errors = 0, cyc = 0;
  int start_cyc = 0, done_n = 0, done_cyc = -1, first_v = -1;

  ram_stream_ctrl #(.SIZE_N(8), .N_BITS(N_BITS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_wr(start_wr), .start_rd(start_rd),
    .base_addr(base_addr), .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rw) ram[ram_addr[2:0]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[2:0]];
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rd_q.push_back(out_data);
      rc_q.push_back(cyc);
    end
    if (ram_rw) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_wdata);
      wc_q.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (out_valid && first_v < 0) first_v = cyc;
  end

  task automatic clear();
    rd_q.delete();
    rc_q.delete();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    done_n = 0;
    done_cyc = -1;
    first_v = -1;
  endtask

  task automatic kick(input bit wr, input bit rd, input int base, input int len);
    @(posedge clk); #1;
    clear();
    start_wr = wr;
    start_rd = rd;
    base_addr = ADDR_W'(base);
    length = LEN_W'(len);
    start_cyc = cyc;
    @(posedge clk); #1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    base_addr = ADDR_W'($urandom);
    length = LEN_W'($urandom);
  endtask

  task automatic do_write(input int base, input int len, input int pct, input bit exp_err);
    int k = 0;
    int n;
    bit acc;
    kick(1'b1, 1'b0, base, len);
    for (int t = 0; t < 300 && done_n == 0; t++) begin
      in_valid = (k < len) && ($urandom_range(99) < pct);
      in_data = in_valid ? wdat[k] : {$urandom, $urandom};
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n = exp_err ? 0 : len;
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL wr_done_count base=%0d len=%0d: got %0d want 1", base, len, done_n); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL wr_err base=%0d len=%0d: got %b want %b", base, len, err, exp_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b want 0", busy); end
    checks++;
    if (wa_q.size() != n) begin
      errors++;
      $display("FAIL wr_count base=%0d len=%0d: got %0d writes want %0d", base, len, wa_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wa_q[i] !== ADDR_W'(base + i) || wd_q[i] !== wdat[i])
          begin errors++; $display("FAIL wr_word%0d: got addr %0d data %h want addr %0d data %h", i, wa_q[i], wd_q[i], base + i, wdat[i]); end
      end
    end
    for (int i = 0; i < n; i++) ref_mem[(base + i) % 8] = wdat[i];
  endtask

  task automatic do_read(input int base, input int len, input int mode);
    out_ready = mode == 0;
    kick(1'b0, 1'b1, base, len);
    for (int t = 0; t < 300 && done_n == 0; t++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (t % 3 == 0) : 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL rd_done_count base=%0d len=%0d: got %0d want 1", base, len, done_n); end
    checks++;
    if (wa_q.size() != 0) begin errors++; $display("FAIL rd_no_write: got %0d writes want 0", wa_q.size()); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err); end
    checks++;
    if (rd_q.size() != len) begin
      errors++;
      $display("FAIL rd_count base=%0d len=%0d mode=%0d: got %0d words want %0d", base, len, mode, rd_q.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        checks++;
        if (rd_q[i] !== ref_mem[(base + i) % 8])
          begin errors++; $display("FAIL rd_word%0d mode=%0d: got %h want %h", i, mode, rd_q[i], ref_mem[(base + i) % 8]); end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, busy, done, err, ram_rw, ram_addr, ram_wdata} !== '0)
      begin errors++; $display("FAIL reset_outputs: got nonzero (busy=%b rw=%b addr=%0d) want all 0", busy, ram_rw, ram_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    for (int i = 0; i < 4; i++) wdat[i] = N_BITS'(10 + i);
    do_write(2, 4, 100, 1'b0);
    for (int i = 0; i < 4 && i < wc_q.size(); i++) begin
      checks++;
      if (wc_q[i] != start_cyc + 2 + i) begin errors++; $display("FAIL wr_cycle%0d: got %0d want %0d", i, wc_q[i], start_cyc + 2 + i); end
    end
    checks++;
    if (done_cyc != start_cyc + 6) begin errors++; $display("FAIL wr_done_time: got %0d want %0d", done_cyc, start_cyc + 6); end
  endtask

  task automatic test_read_basic();
    do_read(2, 4, 0);
    checks++;
    if (first_v != start_cyc + 3) begin errors++; $display("FAIL rd_latency: got %0d want %0d", first_v, start_cyc + 3); end
    for (int i = 0; i < rc_q.size(); i++) begin
      checks++;
      if (rc_q[i] != start_cyc + 3 + i) begin errors++; $display("FAIL rd_stream_cycle%0d: got %0d want %0d", i, rc_q[i], start_cyc + 3 + i); end
    end
  endtask

  task automatic test_read_backpressure();
    do_read(2, 4, 1);
    do_read(0, 8, 1);
  endtask

  task automatic test_both_len0();
    kick(1'b1, 1'b1, 3, 0);
    for (int t = 0; t < 20 && done_n == 0; t++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_n != 1 || done_cyc != start_cyc + 2)
      begin errors++; $display("FAIL len0_done: got %0d pulses at %0d want 1 at %0d", done_n, done_cyc, start_cyc + 2); end
    checks++;
    if (wa_q.size() != 0) begin errors++; $display("FAIL len0_no_write: got %0d writes want 0", wa_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    out_ready = 1'b1;
    kick(1'b0, 1'b1, 2, 4);
    for (int t = 0; t < 20 && rd_q.size() < 1; t++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_data, busy, done, err, ram_rw, ram_addr, ram_wdata} !== '0)
      begin errors++; $display("FAIL midreset_outputs: got busy=%b valid=%b addr=%0d want all 0", busy, out_valid, ram_addr); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_n != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", done_n); end
    do_read(2, 4, 0);
  endtask

  task automatic test_random();
    int b, l;
    for (int r = 0; r < 6; r++) begin
      b = $urandom_range(7);
      l = $urandom_range(8 - b, 1);
      for (int i = 0; i < 16; i++) wdat[i] = {$urandom, $urandom};
      do_write(b, l, 60, 1'b0);
      b = $urandom_range(7);
      l = $urandom_range(8 - b, 1);
      do_read(b, l, 2);
    end
  endtask

  task automatic test_bounds();
    for (int i = 0; i < 16; i++) wdat[i] = {$urandom, $urandom};
    do_write(6, 4, 100, BC);
    if (BC) begin
      checks++;
      if (done_cyc != start_cyc + 2) begin errors++; $display("FAIL bounds_done_time: got %0d want %0d", done_cyc, start_cyc + 2); end
    end
    do_read(0, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram[i] = {$urandom, $urandom};
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_backpressure();
    test_both_len0();
    test_reset_mid_read();
    test_random();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
